// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: repeats a latched WIDTH-bit pattern MSB-first on dout with programmable idle gaps between repeats
module serial_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [REP_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy_o,
    output logic             done_o
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d, sr_q, sr_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dout_d, vld_d, done_d;
    assign ready_o = state_q == IDLE;
    assign busy_o  = ~ready_o;
    // state, datapath and registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            sr_q     <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            sr_q     <= sr_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            dout     <= dout_d;
            dout_vld <= vld_d;
            done_o   <= done_d;
        end
    end
    // next state; sr_q always holds the bit currently on dout at its MSB
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sr_d    = sr_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            pat_d   = '0;
            sr_d    = '0;
            rep_d   = '0;
            gap_d   = '0;
            gcnt_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_d = SHIFT;
                    pat_d   = pattern_i;
                    sr_d    = pattern_i;
                    rep_d   = (repeat_i == '0) ? REP_W'(1) : repeat_i;
                    gap_d   = gap_i;
                    idx_d   = '0;
                    dout_d  = pattern_i[WIDTH-1];
                    vld_d   = 1'b1;
                end
                SHIFT: if (idx_q == IW'(WIDTH-1)) begin
                    idx_d = '0;
                    if (rep_q > REP_W'(1)) begin
                        rep_d = rep_q - REP_W'(1);
                        if (gap_q != '0) begin
                            state_d = GAP;
                            gcnt_d  = gap_q;
                        end else begin
                            sr_d   = pat_q;
                            dout_d = pat_q[WIDTH-1];
                            vld_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        rep_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + IW'(1);
                    sr_d   = sr_q << 1;
                    dout_d = sr_q[WIDTH-2];
                    vld_d  = 1'b1;
                end
                GAP: if (gcnt_q <= GAP_W'(1)) begin
                    state_d = SHIFT;
                    gcnt_d  = '0;
                    idx_d   = '0;
                    sr_d    = pat_q;
                    dout_d  = pat_q[WIDTH-1];
                    vld_d   = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: per-cycle comparison of serial_pattern_tx against a frame-level expected-cycle queue
module tb_serial_pattern_tx;
    localparam int W  = 4;
    localparam int RW = 8;
    localparam int GW = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic start_i = 1'b0, abort_i = 1'b0;
    logic [W-1:0]  pattern_i = '0;
    logic [RW-1:0] repeat_i = '0;
    logic [GW-1:0] gap_i = '0;
    logic ready_o, dout, dout_vld, busy_o, done_o;
    typedef struct packed {logic rdy; logic busy; logic vld; logic dout; logic done;} exp_t;
    localparam exp_t IDLE_E = '{rdy: 1'b1, busy: 1'b0, vld: 1'b0, dout: 1'b0, done: 1'b0};
    exp_t q[$];
    exp_t cur = IDLE_E;
    int checks = 0, errors = 0;
    serial_pattern_tx #(.WIDTH(W), .REP_W(RW), .GAP_W(GW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pattern_i(pattern_i), .repeat_i(repeat_i),
        .gap_i(gap_i), .abort_i(abort_i), .ready_o(ready_o), .dout(dout), .dout_vld(dout_vld),
        .busy_o(busy_o), .done_o(done_o)
    );
    always #5 clk = ~clk;
    // a frame is: n copies of the pattern, gap idle cycles between copies, then one done cycle
    task automatic push_frame(input logic [W-1:0] pat, input int rep, input int gap);
        int n = (rep == 0) ? 1 : rep;
        for (int r = 0; r < n; r++) begin
            for (int b = W - 1; b >= 0; b--) q.push_back('{rdy: 1'b0, busy: 1'b1, vld: 1'b1, dout: pat[b], done: 1'b0});
            if (r < n - 1) for (int g = 0; g < gap; g++) q.push_back('{rdy: 1'b0, busy: 1'b1, vld: 1'b0, dout: 1'b0, done: 1'b0});
        end
        q.push_back('{rdy: 1'b1, busy: 1'b0, vld: 1'b0, dout: 1'b0, done: 1'b1});
    endtask
    task automatic check(input string tag);
        exp_t obs;
        obs = '{rdy: ready_o, busy: busy_o, vld: dout_vld, dout: dout, done: done_o};
        checks++;
        assert (obs === cur) else begin
            errors++;
            $error("FAIL %s: observed rdy/busy/vld/dout/done=%b required=%b", tag, obs, cur);
        end
    endtask
    task automatic step(input string tag);
        @(posedge clk);
        if (abort_i) begin
            q.delete();
            cur = IDLE_E;
        end else begin
            if (start_i && !cur.busy) push_frame(pattern_i, int'(repeat_i), int'(gap_i));
            cur = (q.size() != 0) ? q.pop_front() : IDLE_E;
        end
        #1 check(tag);
    endtask
    task automatic launch(input logic [W-1:0] p, input int r, input int g);
        pattern_i = p;
        repeat_i  = RW'(r);
        gap_i     = GW'(g);
        start_i   = 1'b1;
        step("accept");
        start_i = 1'b0;
    endtask
    initial begin
        #3 check("reset_state");
        @(negedge clk) rst = 1'b0;
        step("idle_after_reset");
        launch(4'b1011, 1, 0);
        repeat (6) step("t1_single");
        launch(4'b1011, 3, 2);
        repeat (18) step("t2_gap2");
        launch(4'b1011, 2, 0);
        repeat (10) step("t3_backtoback");
        launch(4'b1011, 0, 3);
        repeat (6) step("t4_rep0");
        launch(4'b1011, 3, 1);
        abort_i = 1'b1;
        step("t5_abort");
        abort_i = 1'b0;
        repeat (4) step("t5_after_abort");
        start_i = 1'b1; abort_i = 1'b1;
        step("abort_beats_start");
        start_i = 1'b0; abort_i = 1'b0;
        step("abort_beats_start_idle");
        launch(4'b1101, 3, 3);
        repeat (5) step("t5_to_gap");
        rst = 1'b1;
        q.delete();
        cur = IDLE_E;
        #1 check("async_reset_mid_gap");
        @(negedge clk) rst = 1'b0;
        step("after_reset");
        pattern_i = 4'b1011; repeat_i = 1; gap_i = 0; start_i = 1'b1;
        repeat (16) step("t6_start_held");
        start_i = 1'b0;
        launch(4'b1011, 2, 2);
        for (int i = 0; i < 12; i++) begin
            start_i   = i[0];
            pattern_i = W'($urandom);
            repeat_i  = RW'($urandom);
            gap_i     = GW'($urandom);
            step("t6_busy_noise");
        end
        start_i = 1'b0;
        repeat (4) step("t6_drain");
        launch(4'b0110, 255, 0);
        repeat (1022) step("rep_max");
        for (int i = 0; i < 600; i++) begin
            start_i   = ($urandom_range(0, 3) == 0);
            pattern_i = W'($urandom);
            repeat_i  = RW'($urandom_range(0, 4));
            gap_i     = GW'($urandom_range(0, 3));
            abort_i   = ($urandom_range(0, 40) == 0);
            step("random");
        end
        start_i = 1'b0; abort_i = 1'b0;
        repeat (40) step("random_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
